// File: rtl/ac_pkg.sv
// Shared types and constants for the AC fan/compressor driver slice.
// Holds the fan FSM encoding, speed limit, controller modes and the speed-to-duty mapping.
package ac_pkg;

    typedef enum logic [1:0] {
        FAN_IDLE = 2'd0,
        FAN_RAMP = 2'd1,
        FAN_RUN  = 2'd2
    } fan_state_e;

    localparam int unsigned FAN_SPEED_MAX = 4;

    typedef enum logic [1:0] {
        MODE_OFF        = 2'd0,
        MODE_AUTOMATIC  = 2'd1,
        MODE_FAST_COOL  = 2'd2,
        MODE_ECO        = 2'd3
    } ac_mode_e;

    // Speeds above the maximum are clamped, so illegal codes drive full duty.
    function automatic logic [7:0] speed_to_duty(input logic [2:0] fan_speed,
                                                 input int unsigned period);
        int unsigned spd;
        spd = (32'(fan_speed) > FAN_SPEED_MAX) ? FAN_SPEED_MAX : 32'(fan_speed);
        return 8'((spd * period) / FAN_SPEED_MAX);
    endfunction

endpackage

// File: rtl/ac_fan_driver_if.sv
// Bundle between the AC controller (master) and the fan driver (slave).
// AC_FAN_TACH_EN adds the tachometer input and stall flag.
interface ac_fan_driver_if;

    logic [2:0] fan_speed;
    logic [7:0] fan_heat;
    logic       fan_pwm;
    logic [7:0] duty_cur;
    logic       comp_en;
    logic [7:0] coil_setpoint;
    logic       ramping;
    logic       speed_err;
`ifdef AC_FAN_TACH_EN
    logic       fan_tach;
    logic       fan_stall;
`endif

    modport slave (
        input  fan_speed,
        input  fan_heat,
`ifdef AC_FAN_TACH_EN
        input  fan_tach,
        output fan_stall,
`endif
        output fan_pwm,
        output duty_cur,
        output comp_en,
        output coil_setpoint,
        output ramping,
        output speed_err
    );

    modport master (
        output fan_speed,
        output fan_heat,
`ifdef AC_FAN_TACH_EN
        output fan_tach,
        input  fan_stall,
`endif
        input  fan_pwm,
        input  duty_cur,
        input  comp_en,
        input  coil_setpoint,
        input  ramping,
        input  speed_err
    );

endinterface

// File: rtl/ac_pwm_gen.sv
// PWM period counter, ramp tick generation and registered duty compare.
// tick marks the last cycle of every RAMP_PERIODS-th PWM period.
module ac_pwm_gen #(
    parameter int unsigned PWM_PERIOD   = 100,
    parameter int unsigned RAMP_PERIODS = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] duty,
    output logic       fan_pwm,
    output logic       tick
);

    localparam int unsigned PCW = (RAMP_PERIODS > 1) ? $clog2(RAMP_PERIODS) : 1;

    logic [7:0]     pwm_cnt_q, pwm_cnt_d;
    logic [PCW-1:0] period_cnt_q, period_cnt_d;
    logic           fan_pwm_q, fan_pwm_d;
    logic           wrap;

    always_comb begin
        wrap         = (pwm_cnt_q == 8'(PWM_PERIOD - 1));
        tick         = wrap && (period_cnt_q == PCW'(RAMP_PERIODS - 1));
        pwm_cnt_d    = wrap ? '0 : pwm_cnt_q + 8'd1;
        period_cnt_d = period_cnt_q;
        if (tick) begin
            period_cnt_d = '0;
        end else if (wrap) begin
            period_cnt_d = period_cnt_q + PCW'(1);
        end
        fan_pwm_d    = (pwm_cnt_q < duty);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pwm_cnt_q    <= '0;
            period_cnt_q <= '0;
            fan_pwm_q    <= 1'b0;
        end else begin
            pwm_cnt_q    <= pwm_cnt_d;
            period_cnt_q <= period_cnt_d;
            fan_pwm_q    <= fan_pwm_d;
        end
    end

    assign fan_pwm = fan_pwm_q;

endmodule

// File: rtl/ac_fan_driver.sv
// Fan duty soft-ramp FSM with compressor anti-short-cycle lockout and coil setpoint forwarding.
// Optional AC_FAN_TACH_EN adds a tach watchdog that latches fan_stall and shuts the fan down.
module ac_fan_driver
    import ac_pkg::*;
#(
    parameter int unsigned PWM_PERIOD     = 100,
    parameter int unsigned RAMP_PERIODS   = 4,
    parameter int unsigned RAMP_INC       = 5,
    parameter int unsigned MIN_OFF_CYCLES = 1000
`ifdef AC_FAN_TACH_EN
  , parameter int unsigned STALL_CYCLES   = 20000
`endif
) (
    input  logic            clk,
    input  logic            reset,
    ac_fan_driver_if.slave  bus
);

    localparam int unsigned LW = $clog2(MIN_OFF_CYCLES + 1);

    fan_state_e    state_q, state_d;
    logic [7:0]    duty_q, duty_d;
    logic [7:0]    duty_tgt, duty_step;
    logic [7:0]    coil_q, coil_d;
    logic          comp_en_q, comp_en_d;
    logic          speed_err_q, speed_err_d;
    logic [LW-1:0] lockout_q, lockout_d;
    logic          tick;
    logic          stall;
    logic          pwm_out;

    // One ramp step toward the target, landing exactly on it in either direction.
    function automatic logic [7:0] ramp_toward(input logic [7:0] cur, input logic [7:0] tgt);
        int unsigned c, t;
        c = 32'(cur);
        t = 32'(tgt);
        if (c < t) begin
            return (t - c > RAMP_INC) ? 8'(c + RAMP_INC) : tgt;
        end
        return (c - t > RAMP_INC) ? 8'(c - RAMP_INC) : tgt;
    endfunction

    ac_pwm_gen #(
        .PWM_PERIOD   (PWM_PERIOD),
        .RAMP_PERIODS (RAMP_PERIODS)
    ) u_pwm_gen (
        .clk     (clk),
        .reset   (reset),
        .duty    (duty_q),
        .fan_pwm (pwm_out),
        .tick    (tick)
    );

`ifdef AC_FAN_TACH_EN
    localparam int unsigned SW = $clog2(STALL_CYCLES + 1);

    logic          tach_q;
    logic [SW-1:0] wd_q, wd_d;
    logic          stall_q, stall_d;

    always_comb begin
        wd_d    = '0;
        stall_d = stall_q;
        if (state_q == FAN_RUN && duty_q != '0) begin
            if (bus.fan_tach && !tach_q) begin
                wd_d = '0;
            end else if (wd_q != SW'(STALL_CYCLES)) begin
                wd_d = wd_q + SW'(1);
            end else begin
                wd_d = wd_q;
            end
        end
        if (wd_d == SW'(STALL_CYCLES)) begin
            stall_d = 1'b1;
        end
        if (duty_tgt == '0) begin
            stall_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            tach_q  <= 1'b0;
            wd_q    <= '0;
            stall_q <= 1'b0;
        end else begin
            tach_q  <= bus.fan_tach;
            wd_q    <= wd_d;
            stall_q <= stall_d;
        end
    end

    assign stall         = stall_q;
    assign bus.fan_stall = stall_q;
`else
    assign stall = 1'b0;
`endif

    always_comb begin
        duty_tgt  = speed_to_duty(bus.fan_speed, PWM_PERIOD);
        duty_step = ramp_toward(duty_q, duty_tgt);
        state_d   = state_q;
        duty_d    = duty_q;

        unique case (state_q)
            FAN_IDLE: begin
                duty_d = '0;
                if (duty_tgt != '0) begin
                    state_d = FAN_RAMP;
                end
            end
            FAN_RAMP: begin
                if (tick) begin
                    duty_d = duty_step;
                    if (duty_step == duty_tgt) begin
                        state_d = (duty_tgt != '0) ? FAN_RUN : FAN_IDLE;
                    end
                end
            end
            FAN_RUN: begin
                if (duty_tgt != duty_q) begin
                    state_d = FAN_RAMP;
                end
            end
            default: begin
                state_d = FAN_IDLE;
                duty_d  = '0;
            end
        endcase

        if (stall) begin
            state_d = FAN_IDLE;
            duty_d  = '0;
        end

        // Once on, the compressor rides through ramps; only a zero target or stall drops it.
        comp_en_d = (duty_tgt != '0) && !stall &&
                    (comp_en_q || (state_q == FAN_RUN && lockout_q == '0));

        if (comp_en_q && !comp_en_d) begin
            lockout_d = LW'(MIN_OFF_CYCLES);
        end else if (!comp_en_q && lockout_q != '0) begin
            lockout_d = lockout_q - LW'(1);
        end else begin
            lockout_d = lockout_q;
        end

        coil_d      = comp_en_q ? bus.fan_heat : '0;
        speed_err_d = speed_err_q | (bus.fan_speed > 3'(FAN_SPEED_MAX));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= FAN_IDLE;
            duty_q      <= '0;
            comp_en_q   <= 1'b0;
            lockout_q   <= LW'(MIN_OFF_CYCLES);
            coil_q      <= '0;
            speed_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            duty_q      <= duty_d;
            comp_en_q   <= comp_en_d;
            lockout_q   <= lockout_d;
            coil_q      <= coil_d;
            speed_err_q <= speed_err_d;
        end
    end

    assign bus.fan_pwm       = pwm_out;
    assign bus.duty_cur      = duty_q;
    assign bus.comp_en       = comp_en_q;
    assign bus.coil_setpoint = coil_q;
    assign bus.ramping       = (state_q == FAN_RAMP);
    assign bus.speed_err     = speed_err_q;

endmodule

// File: tb/tb_ac_fan_driver.sv
// Self-checking bench for ac_fan_driver: directed pinning checks plus randomized speed/reset traffic.
// A spec-level model tracks edges since reset and predicts every output each cycle.
module tb_ac_fan_driver;

    localparam int P    = 100;
    localparam int R    = 1;
    localparam int INC  = 25;
    localparam int MOFF = 50;

    logic clk = 1'b0;
    logic reset = 1'b1;

    ac_fan_driver_if bus_if();

    ac_fan_driver #(
        .PWM_PERIOD     (P),
        .RAMP_PERIODS   (R),
        .RAMP_INC       (INC),
        .MIN_OFF_CYCLES (MOFF)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_if)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    bit m_valid = 1'b0;
    int k;
    int m_duty, m_lock, m_coil;
    bit m_ramp, m_run, m_comp, m_pwm, m_err;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model indexes time by edges since reset: PWM phase is (k-1)%P, ramp ticks every P*R edges.
    task automatic model_loop();
        int fs, tgt, nduty, nlock, ncoil;
        bit tick, nramp, nrun, ncomp, npwm, nerr;
        forever begin
            @(posedge clk);
            if (reset) begin
                m_valid = 1'b1;
                k = 0;
                m_duty = 0; m_lock = MOFF; m_coil = 0;
                m_ramp = 0; m_run = 0; m_comp = 0; m_pwm = 0; m_err = 0;
            end else if (m_valid) begin
                k++;
                fs    = int'(bus_if.fan_speed);
                tgt   = ((fs > 4) ? 4 : fs) * P / 4;
                tick  = (k % (P * R)) == 0;
                npwm  = ((k - 1) % P) < m_duty;
                nerr  = m_err || (fs > 4);
                ncoil = m_comp ? int'(bus_if.fan_heat) : 0;
                ncomp = (tgt != 0) && (m_comp || (m_run && m_lock == 0));
                if (m_comp && !ncomp)           nlock = MOFF;
                else if (!m_comp && m_lock > 0) nlock = m_lock - 1;
                else                            nlock = m_lock;
                nduty = m_duty; nramp = m_ramp; nrun = m_run;
                if (!m_ramp && !m_run) begin
                    if (tgt != 0) nramp = 1;
                end else if (m_ramp) begin
                    if (tick) begin
                        if (m_duty < tgt) nduty = (m_duty + INC > tgt) ? tgt : m_duty + INC;
                        else              nduty = (m_duty - INC < tgt) ? tgt : m_duty - INC;
                        if (nduty == tgt) begin
                            nramp = 0;
                            nrun  = (tgt != 0);
                        end
                    end
                end else if (tgt != m_duty) begin
                    nrun = 0; nramp = 1;
                end
                m_duty = nduty; m_lock = nlock; m_coil = ncoil;
                m_ramp = nramp; m_run = nrun; m_comp = ncomp; m_pwm = npwm; m_err = nerr;
            end
        end
    endtask

    task automatic compare_loop();
        forever begin
            @(negedge clk);
            if (m_valid) begin
                chk("fan_pwm",       32'(bus_if.fan_pwm),       32'(m_pwm));
                chk("duty_cur",      32'(bus_if.duty_cur),      m_duty);
                chk("comp_en",       32'(bus_if.comp_en),       32'(m_comp));
                chk("coil_setpoint", 32'(bus_if.coil_setpoint), m_coil);
                chk("ramping",       32'(bus_if.ramping),       32'(m_ramp));
                chk("speed_err",     32'(bus_if.speed_err),     32'(m_err));
            end
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        int hi_cnt;
        int hold;
        bus_if.fan_speed = 3'd0;
        bus_if.fan_heat  = 8'h00;
        reset = 1'b1;
        fork
            model_loop();
            compare_loop();
        join_none

        cycles(2);
        chk("rst_duty",    32'(bus_if.duty_cur), 0);
        chk("rst_comp",    32'(bus_if.comp_en), 0);
        chk("rst_ramping", 32'(bus_if.ramping), 0);
        chk("rst_err",     32'(bus_if.speed_err), 0);
        chk("rst_pwm",     32'(bus_if.fan_pwm), 0);
        chk("rst_coil",    32'(bus_if.coil_setpoint), 0);

        // Full-speed ramp from idle: one step per period boundary.
        bus_if.fan_speed = 3'd4;
        bus_if.fan_heat  = 8'h0E;
        reset = 1'b0;
        cycles(99);
        chk("pre_step_duty",  32'(bus_if.duty_cur), 0);
        chk("pre_step_ramp",  32'(bus_if.ramping), 1);
        cycles(1);
        chk("step1_duty", 32'(bus_if.duty_cur), 25);
        cycles(100);
        chk("step2_duty", 32'(bus_if.duty_cur), 50);
        cycles(100);
        chk("step3_duty", 32'(bus_if.duty_cur), 75);
        cycles(100);
        chk("step4_duty", 32'(bus_if.duty_cur), 100);
        chk("run_ramping", 32'(bus_if.ramping), 0);
        chk("comp_before_run", 32'(bus_if.comp_en), 0);
        cycles(1);
        chk("comp_rise", 32'(bus_if.comp_en), 1);
        cycles(1);
        chk("coil_fwd", 32'(bus_if.coil_setpoint), 32'h0E);

        // Down to 75 and measure PWM high time over one full period.
        bus_if.fan_speed = 3'd3;
        cycles(98);
        chk("duty75", 32'(bus_if.duty_cur), 75);
        chk("comp_hold_ramp", 32'(bus_if.comp_en), 1);
        hi_cnt = 0;
        for (int i = 0; i < P; i++) begin
            @(negedge clk);
            if (bus_if.fan_pwm === 1'b1) hi_cnt++;
        end
        chk("pwm_high_count", hi_cnt, 75);

        bus_if.fan_speed = 3'd7;
        cycles(1);
        chk("speed_err_set", 32'(bus_if.speed_err), 1);
        bus_if.fan_speed = 3'd2;
        cycles(5);
        chk("speed_err_sticky", 32'(bus_if.speed_err), 1);
        cycles(200);
        chk("duty50", 32'(bus_if.duty_cur), 50);

        bus_if.fan_speed = 3'd0;
        cycles(1);
        chk("comp_fall", 32'(bus_if.comp_en), 0);
        chk("coil_lag", 32'(bus_if.coil_setpoint), 32'h0E);
        cycles(1);
        chk("coil_zero", 32'(bus_if.coil_setpoint), 0);

        for (int s = 0; s < 60; s++) begin
            if ($urandom_range(0, 7) == 0) begin
                reset = 1'b1;
                cycles(int'($urandom_range(1, 3)));
                reset = 1'b0;
            end else begin
                if ($urandom_range(0, 9) < 8) bus_if.fan_speed = 3'($urandom_range(0, 4));
                else                          bus_if.fan_speed = 3'($urandom_range(5, 7));
                hold = int'($urandom_range(30, 450));
                for (int i = 0; i < hold; i++) begin
                    bus_if.fan_heat = 8'($urandom);
                    @(negedge clk);
                end
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ac_fan_driver.md
Name: ac_fan_driver

Overview:
- Downstream consumer of the AC controller's fan_speed/fan_heat outputs; turns them into a physical fan PWM, compressor enable and coil setpoint.
- Soft-ramps fan duty in PWM-period-aligned steps.
- Enforces a compressor minimum-off (anti-short-cycle) lockout.

Parameters:
- PWM_PERIOD, 100: clk cycles per PWM period; legal range 4..255.
- RAMP_PERIODS, 4: PWM periods between ramp steps; ≥1.
- RAMP_INC, 5: duty counts per ramp step; ≥1.
- MIN_OFF_CYCLES, 1000: compressor lockout length in clk cycles; ≥1.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous reset; active-high
- fan_speed  in  3  requested speed; 0 = off, 1..4 = levels; 5..7 = illegal
- fan_heat  in  8  requested coil setpoint from controller
- fan_pwm  out  1  fan PWM drive, registered
- duty_cur  out  8  current applied duty in clk counts
- comp_en  out  1  compressor enable
- coil_setpoint  out  8  setpoint forwarded to compressor stage
- ramping  out  1  high while state is RAMP
- speed_err  out  1  sticky; set when fan_speed > 4

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, port name reset.
- Reset values:
  - fan_pwm=0, duty_cur=0, comp_en=0, coil_setpoint=0, ramping=0, speed_err=0.
  - pwm_cnt=0, period_cnt=0, state=IDLE.
  - lockout_cnt=MIN_OFF_CYCLES, so the compressor is locked out after power-up.
- Target duty, combinational:
  - spd = min(fan_speed, 4).
  - duty_tgt = spd*PWM_PERIOD/4, integer truncation, 8-bit.
  - fan_speed > 4 sets speed_err and behaves as speed 4.
- PWM:
  - pwm_cnt counts 0..PWM_PERIOD-1 and wraps.
  - fan_pwm <= (pwm_cnt < duty_cur).
  - duty_cur = PWM_PERIOD gives constant high; duty_cur = 0 gives constant low.
- Ramp tick:
  - period_cnt increments on each pwm_cnt wrap.
  - tick is asserted on the wrap where period_cnt == RAMP_PERIODS-1; period_cnt then clears.
  - duty_cur changes only on a tick, so duty only changes at a period boundary.
- FSM states IDLE, RAMP, RUN:
  - IDLE: duty_cur=0. If duty_tgt≠0 → RAMP.
  - RAMP, on each tick:
    - duty_cur moves toward duty_tgt by RAMP_INC, saturating exactly at duty_tgt (up or down).
    - When duty_cur==duty_tgt: go RUN if duty_tgt≠0, else IDLE.
    - The target is re-evaluated every cycle; a mid-ramp change redirects the ramp with no restart.
  - RUN: if duty_tgt≠duty_cur → RAMP.
- Compressor:
  - comp_en rises only when state==RUN and lockout_cnt==0.
  - comp_en falls in the same cycle duty_tgt becomes 0 (registered next edge), in any state.
  - A falling edge of comp_en reloads lockout_cnt=MIN_OFF_CYCLES.
  - lockout_cnt otherwise decrements toward 0 while comp_en=0.
  - comp_en stays 1 through a RAMP between two nonzero targets.
- coil_setpoint <= comp_en ? fan_heat : 0, registered, so it lags comp_en by one cycle.
- ramping = (state==RAMP).
- speed_err clears only on reset.
- Reset mid-operation: all outputs return to reset values on the next edge; the lockout restarts.

Optional Feature:
- Macro: AC_FAN_TACH_EN.
- Defined:
  - Adds input fan_tach (1 bit, pre-synchronised), output fan_stall (1 bit) and parameter STALL_CYCLES (default 20000).
  - In RUN with duty_cur≠0, a watchdog counts cycles since the last fan_tach rising edge; reaching STALL_CYCLES sets fan_stall.
  - fan_stall is sticky. It forces comp_en=0, which starts a lockout, and holds FSM in IDLE with duty 0.
  - fan_stall clears on reset or when duty_tgt==0.
- Undefined: no tach port, no stall port, no watchdog logic.

Decomposition:
- Shared package ac_pkg:
  - FSM state encodings FAN_IDLE/FAN_RAMP/FAN_RUN.
  - FAN_SPEED_MAX=4.
  - Mode constants MODE_OFF/AUTOMATIC/FAST_COOL/ECO.
- One sub-module ac_pwm_gen: pwm_cnt, wrap/tick generation and the compare that produces fan_pwm.
- FSM, ramp and lockout stay in ac_fan_driver.

Test Plan (PWM_PERIOD=100, RAMP_PERIODS=1, RAMP_INC=25, MIN_OFF_CYCLES=50):
- Reset, then fan_speed=4 → duty_cur steps 25,50,75,100 on successive period boundaries, ramping=1 until 100. comp_en stays 0 until 50 cycles after reset, then rises in RUN.
- In RUN at speed 2 (duty 50), fan_speed=0 → comp_en=0 next edge, coil_setpoint=0 one cycle later. Duty ramps 25,0 → IDLE. Re-request speed 2 → comp_en held 0 until 50 cycles after the fall.
- Ramping up to 100 at duty 50, fan_speed changes to 1 → ramp reverses to 25, RUN, comp_en never drops.
- fan_speed=7 → speed_err=1, duty target 100. Then fan_speed=2 → speed_err stays 1.
- duty_cur=75 → fan_pwm high for exactly 75 of every 100 cycles. fan_heat=0x0E with comp_en=1 → coil_setpoint=0x0E.
- Reset asserted mid-ramp at duty 50 → next edge: duty_cur=0, fan_pwm=0, comp_en=0, state IDLE, lockout reloaded.
